// File: rtl/jacobi_sample_driver.sv
// Per-sample sequencer around the jacobi solver: builds b from a scaled
// audio sample, runs one solve, and returns one saturated node voltage.
module jacobi_sample_driver #(
    parameter int SIZE         = 3,
    parameter int PRECISION    = 16,
    parameter int POINT        = 7,
    parameter int SAMPLE_WIDTH = 16,
    parameter int OUT_NODE     = 0
) (
    input  logic                                   clk,
    input  logic                                   I_RSTn,
    input  logic signed [SAMPLE_WIDTH-1:0]         sample_in,
    input  logic                                   sample_valid,
    input  logic signed [PRECISION+POINT-1:0]      in_gain [SIZE],
    output logic signed [PRECISION+POINT-1:0]      b [SIZE],
    output logic                                   start,
    input  logic                                   ready,
    input  logic signed [PRECISION+POINT-1:0]      x [SIZE],
    output logic signed [SAMPLE_WIDTH-1:0]         sample_out,
    output logic                                   sample_out_valid,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam int W  = PRECISION + POINT;
    localparam int PW = W + SAMPLE_WIDTH;
    localparam int EW = (W > SAMPLE_WIDTH ? W : SAMPLE_WIDTH) + 1;
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BUILD  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;

    localparam logic signed [EW-1:0] SMAX = EW'({(SAMPLE_WIDTH-1){1'b1}});
    localparam logic signed [EW-1:0] SMIN = ~SMAX;

    logic [2:0]                     r_state;
    logic [IW-1:0]                  r_idx;
    logic signed [SAMPLE_WIDTH-1:0] r_sample;

    logic signed [PW-1:0]           w_prod;
    logic                           w_bovf;
    logic signed [W-1:0]            w_bsat;
    logic signed [W-1:0]            w_shift;
    logic signed [EW-1:0]           w_ext;
    logic signed [SAMPLE_WIDTH-1:0] w_osat;
    logic                           w_unused;

    // Single shared multiplier; the product already has POINT fraction bits.
    assign w_prod = PW'(in_gain[r_idx]) * PW'(r_sample);
    assign w_bovf = ~(&w_prod[PW-1:W-1]) & (|w_prod[PW-1:W-1]);
    assign w_bsat = w_bovf ? {w_prod[PW-1], {(W-1){~w_prod[PW-1]}}}
                           : w_prod[W-1:0];

    assign w_shift = x[OUT_NODE] >>> POINT;
    assign w_ext   = EW'(w_shift);
    assign w_osat  = (w_ext > SMAX) ? SMAX[SAMPLE_WIDTH-1:0] :
                     (w_ext < SMIN) ? SMIN[SAMPLE_WIDTH-1:0] :
                                      w_ext[SAMPLE_WIDTH-1:0];

    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            w_unused = w_unused ^ (^x[i]);
        end
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_sample         <= '0;
            start            <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overrun          <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                b[i] <= '0;
            end
        end else begin
            start            <= 1'b0;
            sample_out_valid <= 1'b0;
            if (sample_valid && r_state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        r_sample <= sample_in;
                        r_idx    <= '0;
                        r_state  <= S_BUILD;
                    end
                end
                S_BUILD: begin
                    b[r_idx] <= w_bsat;
                    if (r_idx == IW'(SIZE - 1)) begin
                        start   <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_START:  r_state <= S_SETTLE;
                // ready may still be high from the previous solve here
                S_SETTLE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (ready) begin
                        sample_out       <= w_osat;
                        sample_out_valid <= 1'b1;
                        r_state          <= S_OUTPUT;
                    end
                end
                S_OUTPUT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jacobi_sample_driver.md
# jacobi_sample_driver

Per-sample sequencer that sits directly upstream and downstream of the `jacobi` solver in the discrete-circuit audio path. On each accepted audio sample it does three things:
- builds the solver's right-hand-side vector `b` by scaling the sample with a per-node input gain;
- pulses `start` and waits for the solver's `ready`;
- returns one selected node voltage as a saturated audio sample.

The block owns the handshake so that circuit models only supply gains and read samples.

## Interface
Parameters:
- SIZE, 3, number of circuit nodes (solver vector length)
- PRECISION, 16, integer bits of solver fixed-point values
- POINT, 7, fractional bits of solver fixed-point values
- SAMPLE_WIDTH, 16, signed audio sample width
- OUT_NODE, 0, index of `x` driven to `sample_out`

Ports (W = PRECISION+POINT):
- clk  in  1  system clock; one clock domain, all logic on rising edge
- I_RSTn  in  1  reset, synchronous, active-low
- sample_in  in  SAMPLE_WIDTH  signed integer audio sample
- sample_valid  in  1  one-cycle strobe qualifying `sample_in`
- in_gain[SIZE]  in  W each  signed fixed-point gain per node, POINT fractional bits
- b[SIZE]  out  W each  registered RHS vector to solver
- start  out  1  one-cycle solve request to solver
- ready  in  1  solver done/idle
- x[SIZE]  in  W each  solver solution vector
- sample_out  out  SAMPLE_WIDTH  signed output sample
- sample_out_valid  out  1  one-cycle strobe qualifying `sample_out`
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: a sample arrived while busy

## Operation
- States: IDLE, BUILD, START, SETTLE, WAIT, OUTPUT.
- IDLE:
  - `sample_valid`=1 latches `sample_in`, clears the node index, and moves to BUILD.
- BUILD:
  - Uses one shared multiplier and computes one node per cycle, index 0..SIZE-1.
  - b[i] = sat_W(in_gain[i] * sample_in). The product already carries POINT fractional bits, so no shift is applied.
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1].
  - After index SIZE-1, go to START.
- START:
  - `start`=1 for exactly this cycle; `b` is stable and fully written.
- SETTLE:
  - One cycle; `ready` is ignored here because it may still be high from the previous solve.
- WAIT:
  - Stays until `ready`=1, then captures x[OUT_NODE] and goes to OUTPUT.
  - No timeout.
- OUTPUT:
  - `sample_out` = sat_SAMPLE_WIDTH(captured >>> POINT). The shift is arithmetic, so it floors toward negative infinity.
  - `sample_out_valid`=1 for this cycle.
  - Next state is IDLE.
- Overrun:
  - `sample_valid`=1 in any state other than IDLE drops that sample and sets `overrun`.
  - This includes the OUTPUT cycle.
  - `overrun` is cleared only by reset.
- Other vector elements of `x` are ignored.
- `b` holds its value between samples. The solver re-solves only when `start` is pulsed.

## Timing
- Reset (I_RSTn=0 at a rising edge), from any state including mid-BUILD and mid-WAIT:
  - state IDLE
  - all b[i]=0
  - start=0
  - sample_out=0
  - sample_out_valid=0
  - busy=0
  - overrun=0
  - A `sample_valid` in the reset cycle is ignored.
- Cycle schedule, with acceptance at edge 0:
  - BUILD occupies cycles 1..SIZE.
  - `start` is high in cycle SIZE+1.
  - SETTLE is cycle SIZE+2.
  - WAIT begins at SIZE+3.
  - If `ready` is sampled high in cycle k≥SIZE+3, `sample_out_valid` is high in cycle k+1.
- Minimum sample-to-output latency is SIZE+4 cycles plus the solve time.
- `busy` rises the cycle after acceptance and falls in the cycle after OUTPUT.
- The next accept can happen in the first IDLE cycle after OUTPUT.
- `sample_out` holds its value until the next OUTPUT.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Nominal solve.** Setup and stimulus:
  - SIZE=3, POINT=7, in_gain={1<<7,0,0}, sample_in=52.
  - Solver is the real `jacobi` with A={{3,-1,0},{-1,3,-1},{0,-1,2}}<<7 and 8 iterations.
  - Required response: b={52<<7,0,0}, exactly one `start` pulse, then sample_out=19 with one-cycle valid.
  - Repeat with OUT_NODE=1 and OUT_NODE=2 → 7 and 3.
- **Saturation in.** in_gain[0]=4<<7, sample_in=32767 → b[0]=4194303 (2^22-1). With sample_in=-32768 → b[0]=-4194304.
- **Saturation out.** Solver model returns x[0]=40000<<7 → sample_out=32767. x[0]=-1 (raw) → sample_out=-1.
- **Ready latency.** Solver model keeps `ready` high through SETTLE and drops it 2 cycles after `start`, raising it 10 cycles later → exactly one capture, and `sample_out_valid` appears one cycle after `ready` rises.
- **Overrun.** A second `sample_valid` during WAIT and another during OUTPUT:
  - Both samples are dropped, `overrun`=1 and stays 1.
  - The first sample's output is unaffected.
  - A subsequent sample in IDLE is processed normally.
- **Reset mid-operation.** I_RSTn=0 for one cycle during WAIT:
  - All outputs return to reset values.
  - No `sample_out_valid` occurs when `ready` later rises.
  - The next sample completes normally.
